// File: rtl/handshake_initiator.sv
// handshake_initiator: four-phase stb/ack requester; ports clk/rst, req_valid/req_data/req_ready in, stb/stb_data/ack to far side, busy/done/timeout status
module handshake_initiator #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT = 255,
  parameter int TIMEOUT_BITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  req_ready,
  output logic                  stb,
  output logic [DATA_WIDTH-1:0] stb_data,
  input  logic                  ack,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout
);
  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_REL, DRAIN} state_t;
  localparam logic [TIMEOUT_BITS-1:0] LIMIT = TIMEOUT_BITS'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  state_t state, state_nx;
  logic [TIMEOUT_BITS-1:0] cnt, cnt_nx;
  logic [DATA_WIDTH-1:0] data_nx;
  logic stb_nx, done_nx, timeout_nx, accept, expire;
  assign req_ready = state == IDLE && !ack;
  assign accept = req_valid && req_ready;
  assign busy = state != IDLE;
  assign expire = TIMEOUT != 0 && cnt == LIMIT;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    stb_nx = stb;
    data_nx = stb_data;
    done_nx = 1'b0;
    timeout_nx = 1'b0;
    unique case (state)
      IDLE: if (accept) begin
        data_nx = req_data;
        stb_nx = 1'b1;
        cnt_nx = '0;
        state_nx = WAIT_ACK;
      end
      WAIT_ACK: if (ack) begin
        stb_nx = 1'b0;
        state_nx = WAIT_REL;
      end else begin
        cnt_nx = &cnt ? cnt : cnt + TIMEOUT_BITS'(1);
        stb_nx = !expire;
        timeout_nx = expire;
        state_nx = expire ? DRAIN : WAIT_ACK;
      end
      WAIT_REL: if (!ack) begin
        done_nx = 1'b1;
        state_nx = IDLE;
      end
      DRAIN: state_nx = ack ? DRAIN : IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      stb <= 1'b0;
      stb_data <= '0;
      done <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      stb <= stb_nx;
      stb_data <= data_nx;
      done <= done_nx;
      timeout <= timeout_nx;
    end
  end
endmodule

// File: tb/tb_handshake_initiator.sv
// tb_handshake_initiator: directed scoreboard bench for handshake_initiator
module tb_handshake_initiator;
  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, ack = 1'b0;
  logic [31:0] req_data = '0;
  logic req_ready, stb, busy, done, timeout;
  logic [31:0] stb_data;
  logic r4_ready, r4_stb, r4_busy, r4_done, r4_timeout;
  logic [31:0] r4_data;
  int total = 0, bad = 0, dn_cnt = 0, to_cnt = 0;
  logic [31:0] q[$];
  logic [31:0] exp_d;
  always #5 clk = ~clk;
  handshake_initiator #(.DATA_WIDTH(32), .TIMEOUT(8), .TIMEOUT_BITS(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .stb(stb), .stb_data(stb_data), .ack(ack), .busy(busy), .done(done), .timeout(timeout)
  );
  handshake_initiator #(.DATA_WIDTH(32), .TIMEOUT(4), .TIMEOUT_BITS(4)) u4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_ready(r4_ready),
    .stb(r4_stb), .stb_data(r4_data), .ack(ack), .busy(r4_busy), .done(r4_done), .timeout(r4_timeout)
  );
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) if (!rst && (done || timeout)) begin
    total++;
    assert (!(done && timeout)) else begin
      bad++;
      $error("FAIL done_timeout_both observed=1 expected=0");
    end
    total++;
    assert (q.size() != 0) else begin
      bad++;
      $error("FAIL unexpected_pulse observed=%0d expected=0", {done, timeout});
    end
    if (q.size() != 0) begin
      exp_d = q.pop_front();
      total++;
      assert (stb_data === exp_d) else begin
        bad++;
        $error("FAIL sb_data observed=%0h expected=%0h", stb_data, exp_d);
      end
    end
    if (done) dn_cnt++;
    if (timeout) to_cnt++;
  end
  initial begin
    #200000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end
  initial begin
    int acc, dn0, to0;
    logic a;
    tick;
    tick;
    rst = 1'b0;
    chk("rst_stb", stb, 0);
    chk("rst_data", stb_data, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 1);
    req_valid = 1'b1;
    req_data = 32'hDEADBEEF;
    q.push_back(32'hDEADBEEF);
    #1 chk("basic_ready", req_ready, 1);
    tick;
    req_valid = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      if (c == 4) ack = 1'b1;
      if (c == 7) ack = 1'b0;
      chk("basic_stb", stb, c <= 4 ? 1 : 0);
      chk("basic_busy", busy, 1);
      chk("basic_data", stb_data, 32'hDEADBEEF);
      chk("basic_nodone", done, 0);
      tick;
    end
    chk("basic_done", done, 1);
    chk("basic_stb_end", stb, 0);
    chk("basic_data_end", stb_data, 32'hDEADBEEF);
    tick;
    chk("basic_done_pulse", done, 0);
    acc = 0;
    req_valid = 1'b1;
    req_data = 32'h1;
    q.push_back(32'h1);
    for (int i = 0; i < 30 && acc < 2; i++) begin
      ack = stb;
      #1;
      a = req_ready;
      if (a && acc == 1) begin
        chk("b2b_after_done", done, 1);
        chk("b2b_ack_low", ack, 0);
      end
      tick;
      if (a) begin
        acc++;
        if (acc == 1) begin
          req_data = 32'h2;
          q.push_back(32'h2);
        end else req_valid = 1'b0;
      end
      chk("b2b_data", stb_data, acc == 2 ? 32'h2 : 32'h1);
    end
    chk("b2b_accepts", acc, 2);
    for (int i = 0; i < 20 && !done; i++) begin
      ack = stb;
      tick;
    end
    chk("b2b_done2", done, 1);
    ack = 1'b0;
    tick;
    dn0 = dn_cnt;
    to0 = to_cnt;
    req_valid = 1'b1;
    req_data = 32'hA5;
    q.push_back(32'hA5);
    tick;
    req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      chk("to_stb_high", stb, 1);
      chk("to_no_pulse", timeout, 0);
      tick;
    end
    chk("to_stb_drop", stb, 0);
    chk("to_pulse", timeout, 1);
    chk("to_nodone", done, 0);
    tick;
    chk("to_pulse_end", timeout, 0);
    chk("to_idle", busy, 0);
    chk("to_ready", req_ready, 1);
    chk("to_count", to_cnt - to0, 1);
    chk("to_done_count", dn_cnt - dn0, 0);
    dn0 = dn_cnt;
    req_valid = 1'b1;
    req_data = 32'hC3;
    q.push_back(32'hC3);
    tick;
    req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) tick;
    chk("late_timeout", timeout, 1);
    ack = 1'b1;
    tick;
    for (int c = 10; c <= 14; c++) begin
      if (c == 14) ack = 1'b0;
      #1;
      chk("late_busy", busy, 1);
      chk("late_ready", req_ready, 0);
      chk("late_stb", stb, 0);
      chk("late_nodone", done, 0);
      tick;
    end
    chk("late_idle", busy, 0);
    chk("late_ready_end", req_ready, 1);
    chk("late_done_count", dn_cnt - dn0, 0);
    ack = 1'b1;
    req_valid = 1'b1;
    req_data = 32'h77;
    #1 chk("stale_ready", req_ready, 0);
    for (int c = 0; c < 3; c++) begin
      tick;
      chk("stale_stb", stb, 0);
      chk("stale_busy", busy, 0);
    end
    ack = 1'b0;
    req_data = 32'h55;
    tick;
    req_valid = 1'b0;
    chk("rmid_stb", stb, 1);
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rmid_stb0", stb, 0);
    chk("rmid_busy", busy, 0);
    chk("rmid_data", stb_data, 0);
    chk("rmid_done", done, 0);
    chk("rmid_timeout", timeout, 0);
    tick;
    chk("rmid_done2", done, 0);
    chk("rmid_timeout2", timeout, 0);
    chk("rmid_q", q.size(), 0);
    req_valid = 1'b1;
    req_data = 32'h99;
    q.push_back(32'h99);
    tick;
    req_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) ack = 1'b1;
      chk("race_stb", r4_stb, 1);
      tick;
    end
    chk("race_no_timeout", r4_timeout, 0);
    chk("race_stb_drop", r4_stb, 0);
    chk("race_busy", r4_busy, 1);
    ack = 1'b0;
    tick;
    chk("race_done", r4_done, 1);
    chk("race_no_timeout2", r4_timeout, 0);
    chk("race_data", r4_data, 32'h99);
    tick;
    tick;
    chk("sb_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
